mfp_ahb_ip_ctrl: RTL and testbench

AHB-Lite slave that generalises the single image-processing control port into a parametrised bank of control channels with a job handshake. Software programs per-channel control words, then issues GO. The block snapshots the words into shadow outputs, pulses a start strobe to the image-processing pipeline, and tracks busy/done/timeout. It sits on the AHB-Lite bus decoder alongside the other memory-mapped peripherals and drives the IP pipeline directly.

---
 rtl/mfp_ahb_ip_ctrl.sv | 158 +++++++++++++++
 tb/tb_mfp_ahb_ip_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_ip_ctrl.sv
// AHB-Lite control bank for the image-processing pipeline.
// Snapshots per-channel control words on GO and tracks the job.
module mfp_ahb_ip_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [7:0]               HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic                     HSEL,
  input  logic [31:0]              HWDATA,
  output logic [31:0]              HRDATA,
  output logic [NUM_CH*CTRL_W-1:0] IP_CTRL,
  output logic                     IP_START,
  input  logic                     IP_DONE,
  output logic                     IP_BUSY,
  output logic                     IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_t;

  localparam logic [5:0] IDX_CMD  = 6'h10;
  localparam logic [5:0] IDX_STAT = 6'h11;
  localparam logic [5:0] IDX_TMO  = 6'h12;

  state_t            r_state;
  logic              r_we;
  logic              r_re;
  logic [5:0]        r_idx;
  logic [CTRL_W-1:0] r_ctrl [NUM_CH];
  logic [15:0]       r_timeout;
  logic [15:0]       r_wcnt;
  logic [CNT_W-1:0]  r_jobs;
  logic              r_done;
  logic              r_tmo;
  logic              r_ovr;
  logic              r_start;

  logic              w_cmd_wr;
  logic              w_stat_wr;
  logic              w_go;
  logic              w_abort;
  logic [3:1]        w_clr;
  logic              w_in_wait;
  logic              w_set_done;
  logic              w_set_tmo;
  logic              w_set_ovr;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_cmd_wr   = r_we && (r_idx == IDX_CMD);
  assign w_stat_wr  = r_we && (r_idx == IDX_STAT);
  assign w_go       = w_cmd_wr & HWDATA[0];
  assign w_abort    = w_cmd_wr & HWDATA[1];
  assign w_clr      = w_stat_wr ? HWDATA[3:1] : 3'b000;
  assign w_in_wait  = (r_state == S_WAIT);
  assign w_set_done = w_in_wait & IP_DONE;
  assign w_set_tmo  = w_in_wait & ~IP_DONE
                    & (r_timeout != 16'd0)
                    & (r_wcnt == r_timeout - 16'd1);
  assign w_set_ovr  = w_go & (r_state != S_IDLE);
  assign w_unused   = ^{HADDR[1:0], HWDATA};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_we  <= 1'b0;
      r_re  <= 1'b0;
      r_idx <= '0;
    end else begin
      r_we  <= HSEL & HWRITE & (HTRANS != 2'b00);
      r_re  <= HSEL & ~HWRITE & (HTRANS != 2'b00);
      r_idx <= HADDR[7:2];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_CH; i++) r_ctrl[i] <= '0;
      r_timeout <= '0;
    end else if (r_we) begin
      for (int i = 0; i < NUM_CH; i++)
        if (r_idx == 6'(i)) r_ctrl[i] <= HWDATA[CTRL_W-1:0];
      if (r_idx == IDX_TMO) r_timeout <= HWDATA[15:0];
    end
  end

  // Hardware flag sets win over a W1C clear at the same edge
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_start <= 1'b0;
      IP_CTRL <= '0;
      r_wcnt  <= '0;
      r_jobs  <= '0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= (r_done & ~w_clr[1]) | w_set_done;
      r_tmo   <= (r_tmo & ~w_clr[2]) | w_set_tmo;
      r_ovr   <= (r_ovr & ~w_clr[3]) | w_set_ovr;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state <= S_LAUNCH;
            r_start <= 1'b1;
            for (int i = 0; i < NUM_CH; i++)
              IP_CTRL[i*CTRL_W +: CTRL_W] <= r_ctrl[i];
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
          r_wcnt  <= '0;
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + 16'd1;
          if (IP_DONE) begin
            r_state <= S_IDLE;
            r_jobs  <= r_jobs + CNT_W'(1);
          end else if (w_set_tmo | w_abort) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_re) begin
      for (int i = 0; i < NUM_CH; i++)
        if (r_idx == 6'(i)) w_rdata = 32'(r_ctrl[i]);
      if (r_idx == IDX_STAT) begin
        w_rdata[0]            = IP_BUSY;
        w_rdata[1]            = r_done;
        w_rdata[2]            = r_tmo;
        w_rdata[3]            = r_ovr;
        w_rdata[8 +: CNT_W]   = r_jobs;
      end
      if (r_idx == IDX_TMO) w_rdata[15:0] = r_timeout;
    end
  end

  assign HRDATA   = w_rdata;
  assign IP_START = r_start;
  assign IP_BUSY  = (r_state != S_IDLE);
  assign IRQ      = r_done | r_tmo;

endmodule

// File: tb/tb_mfp_ahb_ip_ctrl.sv
// Randomised bench for mfp_ahb_ip_ctrl against a job-level model.
// Job outcome and busy length are derived from done delay vs timeout.
module tb_mfp_ahb_ip_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [7:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic [31:0] IP_CTRL;
  logic        IP_START;
  logic        IP_DONE;
  logic        IP_BUSY;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_ctrl [4];
  logic       m_done;
  logic       m_tmo;
  logic       m_ovr;
  int         m_jobs;

  mfp_ahb_ip_ctrl #(.NUM_CH(4), .CTRL_W(8), .CNT_W(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSEL(HSEL), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .IP_CTRL(IP_CTRL), .IP_START(IP_START), .IP_DONE(IP_DONE),
    .IP_BUSY(IP_BUSY), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d,
                        input logic dn);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    step();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HWDATA = d; IP_DONE = dn;
    step();
    IP_DONE = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    step();
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  function automatic logic [31:0] exp_stat(input logic busy);
    return (32'(m_jobs % 256) << 8)
         | {28'b0, m_ovr, m_tmo, m_done, busy};
  endfunction

  function automatic logic [31:0] exp_ip();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_ctrl[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ctrl[i] = 8'h00;
    m_done = 0; m_tmo = 0; m_ovr = 0; m_jobs = 0;
  endtask

  task automatic clear_flags();
    bus_wr(8'h44, 32'hE, 1'b0);
    m_done = 0; m_tmo = 0; m_ovr = 0;
  endtask

  task automatic run_job(input int k, input int t, input bit use_done,
                         input string nm);
    int busy_n;
    int start_n;
    bit done_exp;
    logic [31:0] rd;
    busy_n = 0;
    start_n = 0;
    bus_wr(8'h40, 32'h1, 1'b0);
    n_checks++;
    if (IP_CTRL !== exp_ip()) begin
      n_fail++;
      $display("FAIL %s ip_ctrl got %h exp %h", nm, IP_CTRL, exp_ip());
    end
    for (int c = 0; c < 300; c++) begin
      if (!IP_BUSY) break;
      busy_n++;
      if (IP_START) start_n++;
      IP_DONE = use_done && (c == k);
      step();
      IP_DONE = 1'b0;
    end
    done_exp = use_done && (t == 0 || k <= t);
    if (done_exp) begin
      m_done = 1; m_jobs++;
    end else begin
      m_tmo = 1;
    end
    n_checks++;
    if (busy_n !== (done_exp ? 1 + k : 1 + t)) begin
      n_fail++;
      $display("FAIL %s busy_cycles got %0d exp %0d k=%0d t=%0d",
               nm, busy_n, done_exp ? 1 + k : 1 + t, k, t);
    end
    n_checks++;
    if (start_n !== 1) begin
      n_fail++;
      $display("FAIL %s start_cycles got %0d exp 1", nm, start_n);
    end
    n_checks++;
    if (IRQ !== 1'b1) begin
      n_fail++;
      $display("FAIL %s irq got %b exp 1", nm, IRQ);
    end
    bus_rd(8'h44, rd);
    n_checks++;
    if (rd !== exp_stat(1'b0)) begin
      n_fail++;
      $display("FAIL %s status got %h exp %h", nm, rd, exp_stat(1'b0));
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [7:0] addrs [7];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h40, 8'h44, 8'h48};
    HRESET = 1'b1;
    step(); step();
    HRESET = 1'b0;
    model_reset();
    n_checks++;
    if ({IP_START, IP_BUSY, IRQ} !== 3'b000 || IP_CTRL !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outs got %b%b%b ctrl %h exp 000 0",
               IP_START, IP_BUSY, IRQ, IP_CTRL);
    end
    n_checks++;
    if (HRDATA !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hrdata got %h exp 0", HRDATA);
    end
    for (int i = 0; i < 7; i++) begin
      bus_rd(addrs[i], rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read %h got %h exp 0", addrs[i], rd);
      end
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd;
    logic [31:0] v;
    logic [7:0] bad [4];
    bad = '{8'h10, 8'h3C, 8'h4C, 8'hFC};
    for (int i = 0; i < 4; i++) begin
      v = (i == 2) ? 32'h5A5A_00A5 : $urandom;
      bus_wr(8'(i * 4), v, 1'b0);
      m_ctrl[i] = v[7:0];
    end
    for (int i = 0; i < 4; i++) begin
      bus_wr(bad[i], $urandom, 1'b0);
      bus_rd(bad[i], rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_fail++;
        $display("FAIL unmapped %h got %h exp 0", bad[i], rd);
      end
    end
    for (int i = 0; i < 4; i++) begin
      bus_rd(8'(i * 4), rd);
      n_checks++;
      if (rd !== {24'h0, m_ctrl[i]}) begin
        n_fail++;
        $display("FAIL ctrl_rd %0d got %h exp %h", i, rd, m_ctrl[i]);
      end
    end
    v = $urandom;
    bus_wr(8'h48, v, 1'b0);
    bus_rd(8'h48, rd);
    n_checks++;
    if (rd !== {16'h0, v[15:0]}) begin
      n_fail++;
      $display("FAIL timeout_rd got %h exp %h", rd, {16'h0, v[15:0]});
    end
    bus_wr(8'h48, 32'h0, 1'b0);
    n_checks++;
    if (IP_CTRL !== 32'h0) begin
      n_fail++;
      $display("FAIL ip_ctrl_pre_go got %h exp 0", IP_CTRL);
    end
    bus_wr(8'h40, 32'h1, 1'b0);
    n_checks++;
    if (IP_CTRL[23:16] !== 8'hA5 || IP_CTRL !== exp_ip()) begin
      n_fail++;
      $display("FAIL ip_ctrl_go got %h exp %h", IP_CTRL, exp_ip());
    end
    n_checks++;
    if (IP_START !== 1'b1 || IP_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL go_start got %b%b exp 11", IP_START, IP_BUSY);
    end
    step();
    n_checks++;
    if (IP_START !== 1'b0 || IP_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL start_width got %b%b exp 01", IP_START, IP_BUSY);
    end
    bus_wr(8'h40, 32'h2, 1'b0);
    bus_rd(8'h44, rd);
    n_checks++;
    if (rd !== exp_stat(1'b0) || IP_CTRL !== exp_ip()) begin
      n_fail++;
      $display("FAIL abort got %h ctrl %h exp %h", rd, IP_CTRL,
               exp_stat(1'b0));
    end
  endtask

  task automatic test_done();
    logic [31:0] rd;
    run_job(5, 0, 1'b1, "done5");
    n_checks++;
    if (m_jobs == 1 && exp_stat(1'b0) !== 32'h102) begin
      n_fail++;
      $display("FAIL done_model got %h exp 102", exp_stat(1'b0));
    end
    bus_wr(8'h44, 32'h2, 1'b0);
    m_done = 0;
    bus_rd(8'h44, rd);
    n_checks++;
    if (rd !== exp_stat(1'b0) || IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL done_w1c got %h irq %b exp %h irq 0",
               rd, IRQ, exp_stat(1'b0));
    end
  endtask

  task automatic test_timeout();
    bus_wr(8'h48, 32'h3, 1'b0);
    run_job(1, 3, 1'b0, "tmo3");
    clear_flags();
    n_checks++;
    if (IRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear irq got %b exp 0", IRQ);
    end
    bus_wr(8'h48, 32'h0, 1'b0);
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    bus_wr(8'h40, 32'h1, 1'b0);
    bus_wr(8'h40, 32'h1, 1'b0);
    m_ovr = 1;
    n_checks++;
    if (IP_START !== 1'b0 || IP_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_restart got %b%b exp 01", IP_START, IP_BUSY);
    end
    bus_rd(8'h44, rd);
    n_checks++;
    if (rd !== exp_stat(1'b1)) begin
      n_fail++;
      $display("FAIL ovr_status got %h exp %h", rd, exp_stat(1'b1));
    end
    bus_wr(8'h40, 32'h2, 1'b1);
    m_done = 1; m_jobs++;
    bus_rd(8'h44, rd);
    n_checks++;
    if (rd !== exp_stat(1'b0)) begin
      n_fail++;
      $display("FAIL abort_done got %h exp %h", rd, exp_stat(1'b0));
    end
    clear_flags();
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd;
    bus_wr(8'h40, 32'h1, 1'b0);
    bus_wr(8'h44, 32'h2, 1'b1);
    m_done = 1; m_jobs++;
    bus_rd(8'h44, rd);
    n_checks++;
    if (rd !== exp_stat(1'b0) || IRQ !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_race got %h irq %b exp %h irq 1",
               rd, IRQ, exp_stat(1'b0));
    end
    clear_flags();
  endtask

  task automatic test_random_jobs();
    int ch, k, t;
    bit ud;
    logic [31:0] v;
    for (int j = 0; j < 12; j++) begin
      ch = $urandom_range(0, 3);
      v = $urandom;
      bus_wr(8'(ch * 4), v, 1'b0);
      m_ctrl[ch] = v[7:0];
      t = $urandom_range(0, 6);
      k = $urandom_range(1, 8);
      ud = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus_wr(8'h48, 32'(t), 1'b0);
      run_job(k, t, ud, "rand_job");
      clear_flags();
    end
    bus_wr(8'h48, 32'h0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    repeat (260) begin
      bus_wr(8'h40, 32'h1, 1'b0);
      step();
      IP_DONE = 1'b1;
      step();
      IP_DONE = 1'b0;
      m_jobs++;
    end
    m_done = 1;
    bus_rd(8'h44, rd);
    n_checks++;
    if (rd !== exp_stat(1'b0)) begin
      n_fail++;
      $display("FAIL wrap got %h exp %h", rd, exp_stat(1'b0));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_wr(8'h40, 32'h1, 1'b0);
    step();
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    model_reset();
    n_checks++;
    if ({IP_START, IP_BUSY, IRQ} !== 3'b000 || IP_CTRL !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset got %b%b%b ctrl %h exp 000 0",
               IP_START, IP_BUSY, IRQ, IP_CTRL);
    end
    bus_rd(8'h44, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_status got %h exp 0", rd);
    end
    bus_rd(8'h08, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_ctrl got %h exp 0", rd);
    end
  endtask

  initial begin
    HRESET = 1'b1; HADDR = '0; HTRANS = '0; HWRITE = 1'b0;
    HSEL = 1'b0; HWDATA = '0; IP_DONE = 1'b0;
    model_reset();
    test_reset();
    test_ctrl();
    test_done();
    test_timeout();
    test_overrun();
    test_w1c_race();
    test_random_jobs();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
